// File: rtl/vga_frame_scheduler.sv
// Arbitrates one single-port sprite RAM between display reads and FIFO-buffered game writes.
// Writes reach the RAM only in vertical blanking. Optional stall statistics: VGA_SCHED_STATS_EN.
module vga_frame_scheduler #(
  parameter int HD         = 640,
  parameter int VD         = 480,
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  input  logic          p_tick,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          video_on,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_valid,
  output logic [DW-1:0] disp_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          frame_start,
  output logic          vblank,
  output logic [15:0]   frame_count,
  output logic [15:0]   stall_count
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {DISP, DRAIN, BLANK} state_t;

  state_t state, state_nxt;

  logic [AW+DW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic             push, pop;
  logic             in_vblank;
  logic             rd_pend;
  logic             frame_hit;
  logic             unused_inputs;

  // Timing inputs that only matter to other consumers of the VGA sync block.
  assign unused_inputs = video_on ^ (x >= 10'(HD));

  assign in_vblank  = (y >= 10'(VD));
  assign frame_hit  = p_tick && (x == 10'd0) && (y == 10'd0);

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign wr_ready   = !fifo_full;
  assign push       = wr_valid && !fifo_full;
  assign pop        = (state == DRAIN) && !disp_req && !fifo_empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) state <= DISP;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      DISP:    if (in_vblank) state_nxt = fifo_empty ? BLANK : DRAIN;
      DRAIN:   if (!in_vblank)     state_nxt = DISP;
               else if (fifo_empty) state_nxt = BLANK;
      BLANK:   if (!in_vblank)     state_nxt = DISP;
               else if (!fifo_empty) state_nxt = DRAIN;
      default: state_nxt = DISP;
    endcase
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_100MHz) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= {wr_addr, wr_data};
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Display reads always win the port; a write is only issued in a cycle with no read request.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rd_pend   <= 1'b0;
    end else begin
      rd_pend <= ram_en && !ram_we;
      if (disp_req) begin
        ram_en   <= 1'b1;
        ram_we   <= 1'b0;
        ram_addr <= disp_addr;
      end else if (pop) begin
        ram_en    <= 1'b1;
        ram_we    <= 1'b1;
        ram_addr  <= fifo_mem[rd_ptr[PW-1:0]][AW+DW-1:DW];
        ram_wdata <= fifo_mem[rd_ptr[PW-1:0]][DW-1:0];
      end else begin
        ram_en <= 1'b0;
        ram_we <= 1'b0;
      end
    end
  end

  assign disp_valid = rd_pend;
  assign disp_data  = rd_pend ? ram_rdata : '0;

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      frame_start <= 1'b0;
      vblank      <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= frame_hit;
      vblank      <= in_vblank;
      if (frame_hit) frame_count <= frame_count + 16'd1;
    end
  end

`ifdef VGA_SCHED_STATS_EN
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset)
      stall_count <= '0;
    else if (wr_valid && !wr_ready && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Scoreboard bench for vga_frame_scheduler: directed stimulus queues expected RAM/display
// transactions with their cycle stamps; a negedge monitor pops and compares them.
module tb_vga_frame_scheduler;

  localparam int AW = 8;
  localparam int DW = 16;
`ifdef VGA_SCHED_STATS_EN
  localparam int STALL_EXP = 5;
`else
  localparam int STALL_EXP = 0;
`endif

  typedef struct {
    int          cyc;
    logic        we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ram_exp_t;

  typedef struct {
    int          cyc;
    logic [DW-1:0] data;
  } disp_exp_t;

  logic          clk_100MHz = 1'b0;
  logic          reset      = 1'b0;
  logic          p_tick     = 1'b0;
  logic [9:0]    x          = '0;
  logic [9:0]    y          = '0;
  logic          video_on   = 1'b0;
  logic          disp_req   = 1'b0;
  logic [AW-1:0] disp_addr  = '0;
  logic          wr_valid   = 1'b0;
  logic [AW-1:0] wr_addr    = '0;
  logic [DW-1:0] wr_data    = '0;
  logic [DW-1:0] ram_rdata  = '0;
  logic          disp_valid, wr_ready, ram_en, ram_we, frame_start, vblank;
  logic [DW-1:0] disp_data, ram_wdata;
  logic [AW-1:0] ram_addr;
  logic [15:0]   frame_count, stall_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  ram_exp_t  ram_q[$];
  disp_exp_t disp_q[$];

  vga_frame_scheduler dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .p_tick     (p_tick),
    .x          (x),
    .y          (y),
    .video_on   (video_on),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .frame_start(frame_start),
    .vblank     (vblank),
    .frame_count(frame_count),
    .stall_count(stall_count)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) cyc <= cyc + 1;

  // RAM stand-in: returns an address-derived pattern one clock after a read.
  always @(posedge clk_100MHz) begin
    if (ram_en && !ram_we) ram_rdata <= 16'hC000 | {8'h00, ram_addr};
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic exp_wr(int c, logic [AW-1:0] a, logic [DW-1:0] d);
    ram_q.push_back('{cyc: c, we: 1'b1, addr: a, data: d});
  endtask

  task automatic push_now(logic [AW-1:0] a, logic [DW-1:0] d);
    check("push_ready", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  always @(negedge clk_100MHz) begin
    if (ram_en) begin
      if (ram_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ram_unexpected: got we=%0d addr=%0h data=%0h expected no access (cycle %0d)",
                 ram_we, ram_addr, ram_wdata, cyc);
      end else begin
        ram_exp_t e;
        e = ram_q.pop_front();
        check("ram_cyc", cyc, e.cyc);
        check("ram_we", {31'd0, ram_we}, {31'd0, e.we});
        check("ram_addr", {24'd0, ram_addr}, {24'd0, e.addr});
        if (e.we) check("ram_wdata", {16'd0, ram_wdata}, {16'd0, e.data});
      end
    end
    if (disp_valid) begin
      if (disp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL disp_unexpected: got data=%0h expected no valid (cycle %0d)", disp_data, cyc);
      end else begin
        disp_exp_t d;
        d = disp_q.pop_front();
        check("disp_cyc", cyc, d.cyc);
        check("disp_data", {16'd0, disp_data}, {16'd0, d.data});
      end
    end
  end

  initial begin
    int c;

    // Reset state
    tick(2);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("rst_disp_valid", {31'd0, disp_valid}, 32'd0);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    check("rst_stall", {16'd0, stall_count}, 32'd0);
    y = 10'd100; x = 10'd5; video_on = 1'b1;
    reset = 1'b1;
    tick(2);

    // Writes held until blanking, then drained in order on consecutive clocks
    push_now(8'h01, 16'hD000);
    push_now(8'h02, 16'hD001);
    push_now(8'h03, 16'hD002);
    tick(5);
    c = cyc;
    y = 10'd480;
    exp_wr(c + 2, 8'h01, 16'hD000);
    exp_wr(c + 3, 8'h02, 16'hD001);
    exp_wr(c + 4, 8'h03, 16'hD002);
    tick();
    check("vblank_set", {31'd0, vblank}, 32'd1);
    tick(6);
    y = 10'd100;
    tick(3);
    check("vblank_clr", {31'd0, vblank}, 32'd0);

    // Full FIFO stalls the fifth write until draining frees a slot
    for (int i = 0; i < 4; i++) push_now(8'h40 + 8'(i), 16'hE000 + 16'(i));
    check("full_ready", {31'd0, wr_ready}, 32'd0);
    wr_valid = 1'b1; wr_addr = 8'h44; wr_data = 16'hE004;
    tick(3);
    check("stall_ready", {31'd0, wr_ready}, 32'd0);
    c = cyc;
    y = 10'd480;
    for (int i = 0; i < 5; i++) exp_wr(c + 2 + i, 8'h40 + 8'(i), 16'hE000 + 16'(i));
    tick();
    check("no_bypass", {31'd0, wr_ready}, 32'd0);
    tick();
    check("drain_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
    tick(6);
    check("stall_count", {16'd0, stall_count}, STALL_EXP);
    y = 10'd100;
    tick(3);

    // Display read pre-empts a pending drain write
    push_now(8'h20, 16'h1111);
    push_now(8'h21, 16'h2222);
    c = cyc;
    y = 10'd480;
    exp_wr(c + 2, 8'h20, 16'h1111);
    ram_q.push_back('{cyc: c + 3, we: 1'b0, addr: 8'h12, data: 16'h0000});
    exp_wr(c + 4, 8'h21, 16'h2222);
    disp_q.push_back('{cyc: c + 4, data: 16'hC012});
    tick(2);
    disp_req = 1'b1; disp_addr = 8'h12;
    tick();
    disp_req = 1'b0;
    tick(4);
    y = 10'd100;
    tick(3);

    // Frame start pulse, qualifiers, and counter wrap
    y = 10'd524; x = 10'd639;
    tick(2);
    check("fs_idle", {31'd0, frame_start}, 32'd0);
    x = 10'd0; y = 10'd0; p_tick = 1'b1;
    tick();
    p_tick = 1'b0; x = 10'd1;
    check("fs_pulse", {31'd0, frame_start}, 32'd1);
    check("fc_one", {16'd0, frame_count}, 32'd1);
    tick();
    check("fs_one_clk", {31'd0, frame_start}, 32'd0);
    x = 10'd0;
    tick();
    check("fs_no_ptick", {31'd0, frame_start}, 32'd0);
    x = 10'd3; p_tick = 1'b1;
    tick();
    p_tick = 1'b0;
    check("fs_x_nonzero", {31'd0, frame_start}, 32'd0);
    check("fc_hold", {16'd0, frame_count}, 32'd1);
    x = 10'd0; p_tick = 1'b1;
    tick(65534);
    p_tick = 1'b0;
    check("fc_max", {16'd0, frame_count}, 32'hFFFF);
    tick();
    p_tick = 1'b1;
    tick();
    p_tick = 1'b0;
    check("fc_wrap", {16'd0, frame_count}, 32'd0);
    check("fs_wrap", {31'd0, frame_start}, 32'd1);
    y = 10'd100; x = 10'd5;
    tick(3);

    // Reset mid-drain with a read in flight and three writes queued
    push_now(8'h30, 16'hF000);
    push_now(8'h31, 16'hF001);
    push_now(8'h32, 16'hF002);
    c = cyc;
    y = 10'd480;
    tick();
    disp_req = 1'b1; disp_addr = 8'h05;
    ram_q.push_back('{cyc: c + 2, we: 1'b0, addr: 8'h05, data: 16'h0000});
    tick();
    disp_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("mid_rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("mid_rst_disp_valid", {31'd0, disp_valid}, 32'd0);
    check("mid_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    tick(2);
    reset = 1'b1;
    tick(10);
    check("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("post_rst_frame_count", {16'd0, frame_count}, 32'd0);
    check("post_rst_stall", {16'd0, stall_count}, 32'd0);
    check("post_rst_vblank", {31'd0, vblank}, 32'd1);

    check("ram_q_drained", ram_q.size(), 32'd0);
    check("disp_q_drained", disp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
